// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the asynchronous SRAM controller slice:
//   - controller state encoding
//   - width of the wait-state counter and its legal range
//   - byte-enable width derivation from the data width
//   - helper that turns the WAIT_CYC parameter into a counter load value
// No ports; imported by sram_ctrl.
// ---------------------------------------------------------------------------
package sram_pkg;

  // Controller states. IDLE is the only state that accepts a request.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_STROBE = 3'd1,
    WR_SETUP  = 3'd2,
    WR_PULSE  = 3'd3,
    WR_HOLD   = 3'd4
  } sram_state_e;

  // The wait counter is 3 bits wide, so at most 7 extra strobe cycles.
  localparam int WAIT_CNT_W = 3;
  localparam int WAIT_MAX   = 7;

  // One byte enable per 8 data bits.
  function automatic int beWidth(input int dataW);
    return dataW / 8;
  endfunction

  // True when a wait-state setting fits the 3-bit counter.
  function automatic bit waitCycLegal(input int w);
    return (w >= 0) && (w <= WAIT_MAX);
  endfunction

  // Counter load value; out-of-range settings saturate instead of wrapping,
  // so a bad parameter gives a slower part rather than a too-fast strobe.
  function automatic logic [WAIT_CNT_W-1:0] waitLoad(input int w);
    if (waitCycLegal(w)) begin
      return WAIT_CNT_W'(w);
    end else if (w < 0) begin
      return '0;
    end else begin
      return WAIT_CNT_W'(WAIT_MAX);
    end
  endfunction

endpackage

// File: rtl/sram_dq_pad.sv
// ---------------------------------------------------------------------------
// sram_dq_pad
// Owns the bidirectional SRAM data bus. The output enable and the outgoing
// write data are both registered so nothing combinational reaches the pins.
// Incoming read data is captured into a register, with disabled bytes forced
// to zero at capture time.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   driveEn_i          next-cycle value of the bus output enable
//   wrLoad_i           load wrData_i into the outgoing data register
//   wrData_i           write data to present on the bus
//   capture_i          sample the bus into the read register this edge
//   capMask_i          per-bit keep mask applied while sampling
//   rdData_o           last captured read data
//   dq_io              SRAM data pins
// ---------------------------------------------------------------------------
module sram_dq_pad #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              driveEn_i,
  input  logic              wrLoad_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] capMask_i,
  output logic [DATA_W-1:0] rdData_o,
  inout  wire  [DATA_W-1:0] dq_io
);

  logic              driveEn_q;
  logic [DATA_W-1:0] wrData_q;
  logic [DATA_W-1:0] rdData_q;

  // Pad registers. Reset releases the bus immediately, which is what lets a
  // reset in the middle of a write leave the pins quiet at that same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      driveEn_q <= 1'b0;
      wrData_q  <= '0;
      rdData_q  <= '0;
    end else begin
      driveEn_q <= driveEn_i;
      if (wrLoad_i) begin
        wrData_q <= wrData_i;
      end
      if (capture_i) begin
        rdData_q <= dq_io & capMask_i;
      end
    end
  end

  assign dq_io    = driveEn_q ? wrData_q : {DATA_W{1'bz}};
  assign rdData_o = rdData_q;

endmodule

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Single-port asynchronous SRAM controller (IS61-class part) sitting between
// user logic and the SRAM pins. One read or write at a time over a
// valid/ready handshake; all strobes, address, byte masks and the data bus
// enable come straight from registers.
// Parameters:
//   ADDR_W    SRAM word address width
//   DATA_W    SRAM data width, a multiple of 8
//   WAIT_CYC  extra strobe cycles for slow parts, 0..7
// Ports:
//   CLOCK_50                 system clock, rising edge
//   reset                    synchronous active-high reset
//   req_valid/req_ready      request handshake, accepted when both high
//   req_we                   1 = write, 0 = read
//   req_addr/req_wdata/req_be  request fields, latched on acceptance
//   rd_valid/rd_data         one-cycle read completion pulse and data
//   busy                     controller is not idle
//   SRAM_DQ/SRAM_ADDR/SRAM_BE_N/SRAM_CE_N/SRAM_OE_N/SRAM_WE_N  SRAM pins
// ---------------------------------------------------------------------------
module sram_ctrl
  import sram_pkg::*;
#(
  parameter  int ADDR_W   = 18,
  parameter  int DATA_W   = 16,
  parameter  int WAIT_CYC = 1,
  localparam int BE_W     = beWidth(DATA_W)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [BE_W-1:0]   SRAM_BE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = waitLoad(WAIT_CYC);

  sram_state_e             state_q,   state_d;
  logic [WAIT_CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [ADDR_W-1:0]       addr_q,    addr_d;
  logic [BE_W-1:0]         beN_q,     beN_d;
  logic                    ceN_q,     ceN_d;
  logic                    oeN_q,     oeN_d;
  logic                    weN_q,     weN_d;
  logic                    rdValid_q, rdValid_d;

  logic                    driveEn;
  logic                    wrLoad;
  logic                    capture;
  logic [DATA_W-1:0]       capMask;

  // State and pin registers. Everything the SRAM sees comes from here, and a
  // synchronous reset returns every strobe high in a single edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      addr_q    <= '0;
      beN_q     <= '1;
      ceN_q     <= 1'b1;
      oeN_q     <= 1'b1;
      weN_q     <= 1'b1;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      addr_q    <= addr_d;
      beN_q     <= beN_d;
      ceN_q     <= ceN_d;
      oeN_q     <= oeN_d;
      weN_q     <= weN_d;
      rdValid_q <= rdValid_d;
    end
  end

  // Next-state logic. Each branch computes the pin values for the cycle that
  // follows the edge, so the strobes switch exactly on state boundaries.
  // Reads hold OE low for WAIT_CYC+1 cycles and sample on the last edge;
  // writes wrap a WAIT_CYC+1 cycle WE pulse in one setup and one hold cycle
  // during which CE, address, masks and data stay put.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    addr_d    = addr_q;
    beN_d     = beN_q;
    ceN_d     = ceN_q;
    oeN_d     = oeN_q;
    weN_d     = weN_q;
    rdValid_d = 1'b0;
    wrLoad    = 1'b0;
    capture   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          beN_d  = ~req_be;
          ceN_d  = 1'b0;
          weN_d  = 1'b1;
          if (req_we) begin
            oeN_d   = 1'b1;
            wrLoad  = 1'b1;
            state_d = WR_SETUP;
          end else begin
            oeN_d     = 1'b0;
            waitCnt_d = WAIT_LOAD;
            state_d   = RD_STROBE;
          end
        end
      end

      RD_STROBE: begin
        if (waitCnt_q == 3'd0) begin
          capture   = 1'b1;
          rdValid_d = 1'b1;
          ceN_d     = 1'b1;
          oeN_d     = 1'b1;
          beN_d     = '1;
          state_d   = IDLE;
        end else begin
          waitCnt_d = waitCnt_q - 3'd1;
        end
      end

      WR_SETUP: begin
        weN_d     = 1'b0;
        waitCnt_d = WAIT_LOAD;
        state_d   = WR_PULSE;
      end

      WR_PULSE: begin
        if (waitCnt_q == 3'd0) begin
          weN_d   = 1'b1;
          state_d = WR_HOLD;
        end else begin
          waitCnt_d = waitCnt_q - 3'd1;
        end
      end

      WR_HOLD: begin
        ceN_d   = 1'b1;
        beN_d   = '1;
        state_d = IDLE;
      end

      default: begin
        ceN_d   = 1'b1;
        oeN_d   = 1'b1;
        weN_d   = 1'b1;
        beN_d   = '1;
        state_d = IDLE;
      end
    endcase
  end

  // The bus is driven in every write state and nowhere else. Deriving the
  // enable from the next state keeps it aligned with the strobes, and since
  // OE is only ever low in RD_STROBE the two can never overlap.
  always_comb begin
    driveEn = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
  end

  // Bytes whose enable was low are zeroed on capture. The masks still hold
  // the request's value on the sampling edge.
  always_comb begin
    capMask = '0;
    for (int b = 0; b < BE_W; b++) begin
      capMask[b*8 +: 8] = {8{~beN_q[b]}};
    end
  end

  sram_dq_pad #(
    .DATA_W(DATA_W)
  ) uPad (
    .clock     (CLOCK_50),
    .reset     (reset),
    .driveEn_i (driveEn),
    .wrLoad_i  (wrLoad),
    .wrData_i  (req_wdata),
    .capture_i (capture),
    .capMask_i (capMask),
    .rdData_o  (rd_data),
    .dq_io     (SRAM_DQ)
  );

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rd_valid  = rdValid_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_BE_N = beN_q;
  assign SRAM_CE_N = ceN_q;
  assign SRAM_OE_N = oeN_q;
  assign SRAM_WE_N = weN_q;

endmodule
